pll_lock_sequencer: RTL

Sequences reset and lock qualification for the two-output system PLL, the 28.636363 MHz video/CPU clock and the 47.727272 MHz memory clock. The block runs on the 50 MHz reference clock. It pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to stay stable before releasing the downstream system reset. It sits between the top-level reset input and the PLL instance, and gates the reset of every logic block clocked from the PLL outputs.

---
 rtl/pll_lock_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock qualification and downstream reset release
//
// Purpose:
//   Runs on the 50 MHz reference clock. Pulses the PLL reset, waits for lock
//   with a timeout and bounded retries, and requires lock to stay stable
//   before releasing the reset of the logic clocked from the PLL outputs.
//
// Optional feature macro: PLL_SEQ_AUTO_RELOCK_EN
//   defined   : loss of lock in RUN restarts the full sequence (new PLL reset
//               pulse, fresh retry budget).
//   undefined : loss of lock in RUN returns to WAIT_LOCK without a PLL reset;
//               the retry count carries over.
//
// Ports:
//   refclk      in   reference clock, the only clock of the block
//   rst_n       in   synchronous active-low reset
//   soft_rst    in   single-cycle request to re-sequence from scratch
//   pll_locked  in   PLL lock indicator, asynchronous to refclk
//   pll_rst     out  PLL reset, active-high, registered
//   sys_rst_n   out  downstream reset, active-low, registered
//   ready       out  high while in RUN
//   fail        out  high while in FAIL
//   retry_cnt   out  retries consumed in the current sequence
module pll_lock_sequencer #(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       soft_rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  localparam int MAX_AB  = (RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  // One shared counter; never narrower than a single bit.
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_cnt_q, retry_cnt_d;
  logic [1:0]       sync_q, sync_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             locked_s;

  // Second synchronizer stage is the only view of lock the FSM ever uses.
  assign locked_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], pll_locked};
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_cnt_d = retry_cnt_q;

    if (soft_rst) begin
      state_d     = S_RESET_PLL;
      cnt_d       = '0;
      retry_cnt_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          // Lock is checked before the timeout so it wins a same-cycle tie.
          if (locked_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_cnt_q >= RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d     = S_RESET_PLL;
              retry_cnt_d = retry_cnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_STABLE: begin
          // Any drop restarts qualification and the lock timeout.
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            state_d     = S_RESET_PLL;
            retry_cnt_d = '0;
`else
            state_d = S_WAIT_LOCK;
`endif
          end
        end

        S_FAIL: begin
          cnt_d = '0;
        end

        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up exactly with the state register.
    pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_cnt_q <= retry_cnt_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_cnt_q;

endmodule
